// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester sync_ram arbiter.
// Requester ids, read-tag layout and the round-robin grant rule live here.
package ram_arb_pkg;

  localparam int unsigned RAM_ADDR_WIDTH = 12;
  localparam int unsigned RAM_DATA_WIDTH = 64;
  localparam int unsigned RAM_COEF_WIDTH = 16;

  typedef enum logic {
    REQ_GEN = 1'b0,
    REQ_MUL = 1'b1
  } req_id_e;

  typedef struct packed {
    logic    valid;
    req_id_e id;
  } rd_tag_t;

  // Bit k of the result is the grant for requester k; on conflict the
  // requester that did not win last time is served.
  function automatic logic [1:0] rr_grant(input logic    req0,
                                          input logic    req1,
                                          input req_id_e last);
    logic [1:0] g;
    g = '0;
    if (req0 && req1) begin
      if (last == REQ_MUL) g = 2'b01;
      else                 g = 2'b10;
    end else begin
      g = {req1, req0};
    end
    return g;
  endfunction

endpackage

// File: rtl/ram_arb_tag_pipe.sv
// Fixed-depth shift register carrying read tags alongside the RAM access,
// so the response stage knows which requester owns the returning word.
module ram_arb_tag_pipe
  import ram_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk,
  input  logic    rstn,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= tag_in;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port sync_ram between the matrix
// generator (requester 0) and the multiplier (requester 1).
// Optional RAM_ARB_STATS_EN adds saturating conflict / wait counters.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ram_wr_en,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [15:0]           stat_conflicts,
  output logic [15:0]           stat_wait1
`endif
);

  req_id_e               last;
  logic [1:0]            gnt;
  logic                  granted;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  rd_tag_t               tag_in;
  rd_tag_t               tag_out;

  assign gnt     = rr_grant(req0, req1, last);
  assign gnt0    = gnt[0];
  assign gnt1    = gnt[1];
  assign granted = |gnt;

  always_comb begin
    sel_we    = we0;
    sel_addr  = addr0;
    sel_wdata = wdata0;
    if (gnt[1]) begin
      sel_we    = we1;
      sel_addr  = addr1;
      sel_wdata = wdata1;
    end
  end

  // last resets to the multiplier so the generator wins the first conflict.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      last <= REQ_MUL;
    end else if (gnt[0]) begin
      last <= REQ_GEN;
    end else if (gnt[1]) begin
      last <= REQ_MUL;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ram_wr_en <= 1'b0;
      ram_rd_en <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
    end else begin
      ram_wr_en <= granted && sel_we;
      ram_rd_en <= granted && !sel_we;
      if (granted) begin
        ram_addr <= sel_addr;
      end
      if (granted && sel_we) begin
        ram_din <= sel_wdata;
      end
    end
  end

  always_comb begin
    tag_in.valid = granted && !sel_we;
    tag_in.id    = gnt[1] ? REQ_MUL : REQ_GEN;
  end

  // One stage for the command register plus RD_LAT stages for the RAM itself.
  ram_arb_tag_pipe #(
    .DEPTH(RD_LAT + 1)
  ) u_tag_pipe (
    .clk    (clk),
    .rstn   (rstn),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata   <= '0;
    end else begin
      rvalid0 <= tag_out.valid && (tag_out.id == REQ_GEN);
      rvalid1 <= tag_out.valid && (tag_out.id == REQ_MUL);
      if (tag_out.valid) begin
        rdata <= ram_dout;
      end
    end
  end

`ifdef RAM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stat_conflicts <= '0;
      stat_wait1     <= '0;
    end else begin
      if (req0 && req1 && (stat_conflicts != '1)) begin
        stat_conflicts <= stat_conflicts + 16'd1;
      end
      if (req1 && !gnt[1] && (stat_wait1 != '1)) begin
        stat_wait1 <= stat_wait1 + 16'd1;
      end
    end
  end
`endif

endmodule
